// File: rtl/circle_pkg.sv
// Shared types and constants for the circle scheduler: colours, screen size,
// scheduler states and the queued command layout.
package circle_pkg;

    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

    localparam int unsigned SCREEN_WIDTH  = 160;
    localparam int unsigned SCREEN_HEIGHT = 120;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ENG,
        ST_CLEAR
    } state_e;

    typedef struct packed {
        logic       clear;
        logic [7:0] cx;
        logic [7:0] cy;
        logic [7:0] r;
        logic [2:0] colour;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; dout shows the head whenever
// empty is low. DEPTH must be a power of two.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 28
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic            do_push, do_pop;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/circle_scheduler.sv
// Queues circle/clear commands, launches the circle engine one command at a
// time, sweeps screen clears itself and drives the registered VGA pixel port.
module circle_scheduler #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SCREEN_WIDTH  = 160,
    parameter int unsigned SCREEN_HEIGHT = 120,
    parameter int unsigned ENG_TIMEOUT   = 65535
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_clear,
    input  logic [7:0] cmd_centerx,
    input  logic [7:0] cmd_centery,
    input  logic [7:0] cmd_radius,
    input  logic [2:0] cmd_colour,
    output logic       eng_start,
    output logic [7:0] eng_centerx,
    output logic [7:0] eng_centery,
    output logic [7:0] eng_radius,
    input  logic [7:0] eng_x,
    input  logic [7:0] eng_y,
    input  logic       eng_plot,
    input  logic       eng_done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic [2:0] queue_count,
    output logic       err
);
    import circle_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = $clog2(ENG_TIMEOUT + 1);
    localparam logic [7:0]    X_LAST  = 8'(SCREEN_WIDTH - 1);
    localparam logic [7:0]    Y_LAST  = 8'(SCREEN_HEIGHT - 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(ENG_TIMEOUT);

    cmd_t          fifo_din, fifo_dout;
    logic          fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0] fifo_count;

    state_e        state_q, state_d;
    logic [7:0]    cx_q, cx_d, cy_q, cy_d, r_q, r_d;
    logic [2:0]    colour_q, colour_d;
    logic [7:0]    sx_q, sx_d;
    logic [6:0]    sy_q, sy_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          eng_start_q, eng_start_d;
    logic [7:0]    vga_x_q, vga_x_d;
    logic [6:0]    vga_y_q, vga_y_d;
    logic [2:0]    vga_colour_q, vga_colour_d;
    logic          vga_plot_q, vga_plot_d;

    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_din  = '{clear: cmd_clear, cx: cmd_centerx, cy: cmd_centery,
                         r: cmd_radius, colour: cmd_colour};

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (CLOCK_50),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        r_d          = r_q;
        colour_d     = colour_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        tmo_d        = tmo_q;
        err_d        = err_q;
        eng_start_d  = 1'b0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    cx_d        = fifo_dout.cx;
                    cy_d        = fifo_dout.cy;
                    r_d         = fifo_dout.r;
                    colour_d    = fifo_dout.colour;
                    sx_d        = '0;
                    sy_d        = '0;
                    tmo_d       = '0;
                    eng_start_d = !fifo_dout.clear;
                    state_d     = fifo_dout.clear ? ST_CLEAR : ST_ISSUE;
                end
            end
            // Counter is zero during ISSUE and counts every cycle after it,
            // so the abort lands exactly ENG_TIMEOUT cycles after ISSUE.
            ST_ISSUE: begin
                tmo_d   = tmo_q + TW'(1);
                state_d = ST_WAIT_ENG;
            end
            ST_WAIT_ENG: begin
                vga_plot_d   = eng_plot && (eng_x <= X_LAST) && (eng_y <= Y_LAST);
                vga_x_d      = eng_x;
                vga_y_d      = eng_y[6:0];
                vga_colour_d = colour_q;
                tmo_d        = tmo_q + TW'(1);
                if (eng_done) begin
                    state_d = ST_IDLE;
                end else if ((tmo_q + TW'(1)) == TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                vga_plot_d   = 1'b1;
                vga_x_d      = sx_q;
                vga_y_d      = sy_q;
                vga_colour_d = colour_q;
                if (sx_q == X_LAST) begin
                    sx_d = '0;
                    if (sy_q == Y_LAST[6:0]) state_d = ST_IDLE;
                    else                     sy_d = sy_q + 7'd1;
                end else begin
                    sx_d = sx_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cx_q         <= '0;
            cy_q         <= '0;
            r_q          <= '0;
            colour_q     <= '0;
            sx_q         <= '0;
            sy_q         <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            eng_start_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            r_q          <= r_d;
            colour_q     <= colour_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            tmo_q        <= tmo_d;
            err_q        <= err_d;
            eng_start_q  <= eng_start_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign eng_start   = eng_start_q;
    assign eng_centerx = cx_q;
    assign eng_centery = cy_q;
    assign eng_radius  = r_q;
    assign vga_x       = vga_x_q;
    assign vga_y       = vga_y_q;
    assign vga_colour  = vga_colour_q;
    assign vga_plot    = vga_plot_q;
    assign busy        = (state_q != ST_IDLE) || !fifo_empty;
    assign queue_count = 3'(fifo_count);
    assign err         = err_q;

endmodule
